if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the PC loaded at reset and the flush value of if_PC.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 stall  in  1  downstream register cannot accept the output slot this cycle.
REQ-005 br_flag  in  1  branch/jump taken; flush and redirect fetch.
REQ-006 br_target  in  32  redirect address, valid when br_flag=1.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  fetch address, always equal to the pc register.
REQ-009 imem_rdata  in  32  instruction word, valid when imem_req && imem_ready.
REQ-010 imem_ready  in  1  completes the request in the same cycle.
REQ-011 if_PC  out  32  PC of the presented instruction.
REQ-012 if_instr  out  32  presented instruction; 0 (bubble) when if_valid=0.
REQ-013 if_valid  out  1  output slot holds a real instruction.

Function
REQ-014 State: pc(32), tgt(32), FSM {FETCH, DROP}, output slot (if_valid/if_PC/if_instr), one-entry skid (sk_valid/sk_PC/sk_instr); all registered.
REQ-015 Handshake hs = imem_req && imem_ready; imem_req = rstn && ((FETCH && !sk_valid) || DROP).
REQ-016 Protocol: once imem_req=1, imem_req and imem_addr are held stable until hs.
REQ-017 FETCH, hs, br_flag=0: pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Slot consumed when if_valid=0 or stall=0; slot held unchanged when if_valid=1 and stall=1.
REQ-019 Slot held and FETCH hs: skid <= {pc, imem_rdata}, sk_valid=1; imem_req drops next cycle.
REQ-020 Slot consumed, sk_valid=1: slot <= skid, sk_valid <= 0 (skid has priority over memory).
REQ-021 Slot consumed, sk_valid=0, FETCH hs: slot <= {pc, imem_rdata}, if_valid=1; same-cycle latency from hs to slot load is one clock.
REQ-022 Slot consumed, nothing available: if_valid <= 0, if_instr <= 0, if_PC unchanged.
REQ-023 br_flag=1 overrides stall: if_valid <= 0, if_instr <= 0, if_PC <= RESET_PC, sk_valid <= 0.
REQ-024 br_flag=1 with hs or imem_req=0: pc <= {br_target[31:2],2'b00}, next state FETCH, any returned data discarded.
REQ-025 br_flag=1 with imem_req=1 and imem_ready=0: tgt <= {br_target[31:2],2'b00}, next state DROP, pc unchanged.
REQ-026 DROP: imem_req=1 at old pc; on hs data discarded, pc <= tgt, next state FETCH; no slot/skid load in DROP.
REQ-027 br_flag in DROP: tgt updated to newest target; if coincident with hs, pc <= new target directly.
REQ-028 Instruction order preserved; no instruction duplicated or lost absent br_flag.

Reset
REQ-029 rstn=0 at a clock edge: pc=RESET_PC, tgt=RESET_PC, FSM=FETCH, if_valid=0, if_instr=0, if_PC=RESET_PC, sk_valid=0.
REQ-030 imem_req=0 while rstn=0; reset mid-request abandons it and any DROP; fetch restarts at RESET_PC the cycle after rstn=1.

Verification
REQ-031 Reset then imem_ready=1 constant, stall=0 -> imem_addr 3000,3004,3008; if_PC trails by one cycle, if_valid=1 from second cycle.
REQ-032 stall=1 for 3 cycles while ready=1 -> slot holds 3004, skid takes 3008, imem_req=0; stall release -> 3008 then 300C presented, no gaps/duplicates.
REQ-033 br_flag=1, br_target=32'h0000_4001, ready=1 -> next if_valid=0, if_instr=0, if_PC=3000; next imem_addr=4000.
REQ-034 br_flag with ready=0 (3-cycle latency) -> DROP, imem_addr held at old pc until ready, data discarded, then imem_addr=target.
REQ-035 br_flag and stall=1 same cycle with full skid -> slot and skid flushed, stall ignored.
REQ-036 pc=32'hFFFF_FFFC, hs -> next imem_addr=0; rstn=0 during DROP -> next fetch at 3000.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a single-cycle-handshake memory port.
//
// Fetches sequential instruction words from instruction memory and presents
// them one at a time in a registered output slot. A one-entry skid buffer
// catches the word that returns while the slot is stalled. A taken branch
// flushes both the slot and the skid and redirects fetch. If the branch
// arrives while a request is still outstanding, the FSM enters DROP. In DROP
// the old request completes, its data is thrown away, and fetch then
// continues at the branch target.
//
// Ports
//   clk         in   rising-edge clock
//   rstn        in   synchronous active-low reset
//   stall       in   downstream cannot take the output slot this cycle
//   br_flag     in   branch/jump taken: flush and redirect
//   br_target   in   redirect address (low two bits ignored)
//   imem_req    out  instruction memory request
//   imem_addr   out  fetch address (the pc register)
//   imem_rdata  in   instruction word, valid on handshake
//   imem_ready  in   completes the request in the same cycle
//   if_PC       out  PC of the presented instruction
//   if_instr    out  presented instruction, 0 when if_valid=0
//   if_valid    out  output slot holds a real instruction
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_PC,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  typedef enum logic {FETCH = 1'b0, DROP = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] tgt_reg, tgt_next;

  logic        slot_valid_reg;
  logic [31:0] slot_pc_reg, slot_instr_reg;
  logic        sk_valid_reg;
  logic [31:0] sk_pc_reg, sk_instr_reg;

  logic        hs;
  logic        fetch_hs;
  logic        slot_free;
  logic [31:0] br_addr;

  // A full skid blocks new requests. This keeps at most two words in flight
  // between the memory and the downstream stage, so no returned word is
  // lost. DROP always requests, so the request it inherited stays stable.
  assign imem_req  = rstn && (((state_reg == FETCH) && !sk_valid_reg) || (state_reg == DROP));
  assign imem_addr = pc_reg;
  assign hs        = imem_req && imem_ready;
  assign fetch_hs  = hs && (state_reg == FETCH);
  assign slot_free = !slot_valid_reg || !stall;
  assign br_addr   = br_target & 32'hFFFF_FFFC;

  assign if_valid  = slot_valid_reg;
  assign if_PC     = slot_pc_reg;
  assign if_instr  = slot_instr_reg;

  // Fetch-address FSM: next state, next pc and pending target.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    tgt_next   = tgt_reg;
    if (br_flag) begin
      if (hs || !imem_req) begin
        // Nothing left outstanding, so the redirect can happen right away.
        pc_next    = br_addr;
        state_next = FETCH;
      end else begin
        // The outstanding request must finish at its current address first.
        tgt_next   = br_addr;
        state_next = DROP;
      end
    end else if (state_reg == DROP) begin
      if (hs) begin
        pc_next    = tgt_reg;
        state_next = FETCH;
      end
    end else if (hs) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      tgt_reg   <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      tgt_reg   <= tgt_next;
    end
  end

  // Output slot and skid buffer. When the slot frees up, a word in the skid
  // takes priority over memory, which keeps program order. A word returned
  // in DROP is never loaded.
  always_ff @(posedge clk) begin
    if (!rstn || br_flag) begin
      slot_valid_reg <= 1'b0;
      slot_instr_reg <= 32'd0;
      slot_pc_reg    <= RESET_PC;
      sk_valid_reg   <= 1'b0;
      if (!rstn) begin
        sk_pc_reg    <= RESET_PC;
        sk_instr_reg <= 32'd0;
      end
    end else if (slot_free) begin
      if (sk_valid_reg) begin
        slot_valid_reg <= 1'b1;
        slot_pc_reg    <= sk_pc_reg;
        slot_instr_reg <= sk_instr_reg;
        sk_valid_reg   <= 1'b0;
      end else if (fetch_hs) begin
        slot_valid_reg <= 1'b1;
        slot_pc_reg    <= pc_reg;
        slot_instr_reg <= imem_rdata;
      end else begin
        // Bubble: keep the last PC and zero the instruction.
        slot_valid_reg <= 1'b0;
        slot_instr_reg <= 32'd0;
      end
    end else if (fetch_hs) begin
      sk_valid_reg <= 1'b1;
      sk_pc_reg    <= pc_reg;
      sk_instr_reg <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// Runs directed scenarios first, then randomized cycles. Each cycle is
// checked against a transaction-level model: a fetch pointer, a pending
// redirect, and a FIFO of fetched-but-unconsumed words. The head of the
// FIFO is the presented slot.
// ---------------------------------------------------------------------------
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rstn, stall, br_flag, imem_ready;
  logic [31:0] br_target, imem_rdata, imem_addr, if_PC, if_instr;
  logic        imem_req, if_valid;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .br_flag(br_flag),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_PC(if_PC), .if_instr(if_instr), .if_valid(if_valid)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc   = RST_PC;
  logic [31:0] m_tgt  = RST_PC;
  logic [31:0] m_ifpc = RST_PC;
  bit          m_drop = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Apply the inputs, then check the request side before
  // the edge. Advance the model across the edge, then check the slot.
  task automatic step(input logic r, input logic s, input logic b,
                      input logic [31:0] t, input logic rd);
    bit          req, hs;
    logic [31:0] exp_instr;
    rstn = r; stall = s; br_flag = b; br_target = t; imem_ready = rd;
    #1;
    req = r && (m_drop || m_q.size() < 2);
    hs  = req && rd;
    chk("imem_req", {31'd0, imem_req}, {31'd0, req});
    chk("imem_addr", imem_addr, m_pc);
    @(posedge clk); #1;
    if (!r) begin
      m_q.delete(); m_pc = RST_PC; m_tgt = RST_PC; m_drop = 1'b0; m_ifpc = RST_PC;
    end else if (b) begin
      m_q.delete();
      m_ifpc = RST_PC;
      if (hs || !req) begin
        m_pc = t & 32'hFFFF_FFFC; m_drop = 1'b0;
      end else begin
        m_tgt = t & 32'hFFFF_FFFC; m_drop = 1'b1;
      end
    end else if (m_drop) begin
      if (hs) begin
        m_pc = m_tgt; m_drop = 1'b0;
      end
    end else begin
      if (!s && m_q.size() > 0) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    if (m_q.size() > 0) m_ifpc = m_q[0].pc;
    exp_instr = (m_q.size() > 0) ? m_q[0].ins : 32'd0;
    chk("if_valid", {31'd0, if_valid}, {31'd0, (m_q.size() > 0)});
    chk("if_PC", if_PC, m_ifpc);
    chk("if_instr", if_instr, exp_instr);
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; br_flag = 1'b0; br_target = 32'd0; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_PC, RST_PC);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);

    // Streaming with ready held high.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("seq_pc0", if_PC, 32'h3000);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("seq_pc1", if_PC, 32'h3004);

    // Three stall cycles: the skid fills, then requests stop.
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_hold", if_PC, 32'h3004);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_hold3", if_PC, 32'h3004);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("skid_out", if_PC, 32'h3008);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("after_skid", if_PC, 32'h300C);

    // Branch with ready: redirect on the next cycle.
    step(1'b1, 1'b0, 1'b1, 32'h0000_4001, 1'b1);
    chk("br_pc", if_PC, RST_PC);
    chk("br_addr", imem_addr, 32'h4000);

    // Branch with the memory not ready: DROP holds the old address.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_5000, 1'b0);
    chk("drop_hold", imem_addr, 32'h4004);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("drop_done", imem_addr, 32'h5000);

    // Branch while stalled with a full skid.
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_6000, 1'b1);
    chk("flush_pc", if_PC, RST_PC);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("flush_next", if_PC, 32'h6000);

    // Address wrap at the top of the space.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_zero", imem_addr, 32'd0);

    // Reset while in DROP.
    step(1'b1, 1'b0, 1'b1, 32'h0000_7000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("rst_drop_pc", if_PC, 32'h3000);

    // Randomized cycles.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 6),
           $urandom,
           ($urandom_range(0, 99) < 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
